fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the main decoder in the RISC-V core.
- Owns the program counter and issues in-order word requests to instruction memory.
- Holds returned instructions in a small prefetch buffer and presents them, with their PC, to decode over a valid/ready handshake.
- Flushes and restarts on a redirect from branch/jump resolution.

---
 rtl/fetch_unit.sv | 130 +++++++++++++
 tb/tb_fetch_unit.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: RISC-V instruction fetch stage with PC, credit-limited prefetch buffer and redirect flush.
//   Ports: i_CLK, i_RST_N (async active-low reset);
//          o_IMemReq/o_IMemAddr/i_IMemGnt request side, i_IMemRValid/i_IMemRData in-order responses;
//          o_InstrValid/o_Instr/o_PC/o_PCPlus4/i_InstrReady decode handshake;
//          i_Redirect/i_RedirectPC fetch restart.
//   Optional macro FETCH_MISALIGN_TRAP_EN adds o_Misaligned and a HALT state for misaligned redirects.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            i_CLK,
  input  logic            i_RST_N,
  output logic            o_IMemReq,
  output logic [XLEN-1:0] o_IMemAddr,
  input  logic            i_IMemGnt,
  input  logic            i_IMemRValid,
  input  logic [XLEN-1:0] i_IMemRData,
  output logic            o_InstrValid,
  output logic [XLEN-1:0] o_Instr,
  output logic [XLEN-1:0] o_PC,
  output logic [XLEN-1:0] o_PCPlus4,
  input  logic            i_InstrReady,
  input  logic            i_Redirect,
  input  logic [XLEN-1:0] i_RedirectPC
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic            o_Misaligned
`endif
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);
  typedef enum logic [1:0] {RUN, FLUSH, HALT} state_e;
  state_e          state_q, state_d;
  logic            live_q, live_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   outst_q, outst_d, count_q, count_d;
  logic [PW-1:0]   if_wr_q, if_wr_d, if_rd_q, if_rd_d, b_wr_q, b_wr_d, b_rd_q, b_rd_d;
  logic [XLEN-1:0] if_addr_q [DEPTH];
  logic [XLEN-1:0] if_addr_d [DEPTH];
  logic [XLEN-1:0] buf_pc_q  [DEPTH];
  logic [XLEN-1:0] buf_pc_d  [DEPTH];
  logic [XLEN-1:0] buf_ins_q [DEPTH];
  logic [XLEN-1:0] buf_ins_d [DEPTH];
  logic            gnt, pop, push, bad_pc;
  logic [XLEN-1:0] redir_pc;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
`ifdef FETCH_MISALIGN_TRAP_EN
  logic misal_q, misal_d;
  assign bad_pc       = |i_RedirectPC[1:0];
  assign redir_pc     = i_RedirectPC;
  assign misal_d      = i_Redirect ? bad_pc : misal_q;
  assign o_Misaligned = misal_q;
  always_ff @(posedge i_CLK or negedge i_RST_N)
    if (!i_RST_N) misal_q <= 1'b0;
    else misal_q <= misal_d;
`else
  assign bad_pc   = 1'b0;
  assign redir_pc = i_RedirectPC & ~XLEN'(3);
`endif
  assign gnt  = o_IMemReq & i_IMemGnt;
  assign pop  = o_InstrValid & i_InstrReady;
  // responses only land in the buffer while running and not being flushed this cycle
  assign push = i_IMemRValid & (state_q == RUN) & ~i_Redirect;
  always_ff @(posedge i_CLK or negedge i_RST_N)
    if (!i_RST_N) state_q <= RUN;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    if (i_Redirect) state_d = bad_pc ? HALT : (outst_d != '0) ? FLUSH : RUN;
    else if (state_q == FLUSH && outst_d == '0) state_d = RUN;
  end
  always_comb begin
    o_IMemReq    = live_q & (state_q == RUN) &
                   (({1'b0, count_q} + {1'b0, outst_q}) < (CW+1)'(DEPTH));
    o_IMemAddr   = fetch_pc_q;
    o_InstrValid = count_q != '0;
    o_Instr      = o_InstrValid ? buf_ins_q[b_rd_q] : NOP;
    o_PC         = o_InstrValid ? buf_pc_q[b_rd_q] : (state_q == HALT) ? fetch_pc_q : '0;
    o_PCPlus4    = o_PC + XLEN'(4);
  end
  always_comb begin
    live_d     = 1'b1;
    fetch_pc_d = i_Redirect ? redir_pc : gnt ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
    // stale responses still retire their in-flight slot so the queue stays aligned with outst_q
    outst_d    = outst_q + CW'(gnt) - CW'(i_IMemRValid);
    count_d    = i_Redirect ? '0 : count_q + CW'(push) - CW'(pop);
    if_wr_d    = gnt ? inc(if_wr_q) : if_wr_q;
    if_rd_d    = i_IMemRValid ? inc(if_rd_q) : if_rd_q;
    b_wr_d     = i_Redirect ? '0 : push ? inc(b_wr_q) : b_wr_q;
    b_rd_d     = i_Redirect ? '0 : pop ? inc(b_rd_q) : b_rd_q;
    if_addr_d  = if_addr_q;
    buf_pc_d   = buf_pc_q;
    buf_ins_d  = buf_ins_q;
    if (gnt) if_addr_d[if_wr_q] = fetch_pc_q;
    if (push) begin
      buf_pc_d[b_wr_q]  = if_addr_q[if_rd_q];
      buf_ins_d[b_wr_q] = i_IMemRData;
    end
  end
  always_ff @(posedge i_CLK or negedge i_RST_N)
    if (!i_RST_N) begin
      live_q     <= 1'b0;
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      count_q    <= '0;
      if_wr_q    <= '0;
      if_rd_q    <= '0;
      b_wr_q     <= '0;
      b_rd_q     <= '0;
      if_addr_q  <= '{default: '0};
      buf_pc_q   <= '{default: '0};
      buf_ins_q  <= '{default: '0};
    end else begin
      live_q     <= live_d;
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      count_q    <= count_d;
      if_wr_q    <= if_wr_d;
      if_rd_q    <= if_rd_d;
      b_wr_q     <= b_wr_d;
      b_rd_q     <= b_rd_d;
      if_addr_q  <= if_addr_d;
      buf_pc_q   <= buf_pc_d;
      buf_ins_q  <= buf_ins_d;
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with an in-order latency memory model.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        i_RST_N = 1'b0;
  logic        o_IMemReq, i_IMemGnt = 1'b0, i_IMemRValid = 1'b0;
  logic [31:0] o_IMemAddr, i_IMemRData = '0;
  logic        o_InstrValid, i_InstrReady = 1'b0, i_Redirect = 1'b0;
  logic [31:0] o_Instr, o_PC, o_PCPlus4, i_RedirectPC = '0;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        o_Misaligned;
`endif
  always #5 clk = ~clk;
  fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
    .i_CLK(clk), .i_RST_N(i_RST_N),
    .o_IMemReq(o_IMemReq), .o_IMemAddr(o_IMemAddr), .i_IMemGnt(i_IMemGnt),
    .i_IMemRValid(i_IMemRValid), .i_IMemRData(i_IMemRData),
    .o_InstrValid(o_InstrValid), .o_Instr(o_Instr), .o_PC(o_PC), .o_PCPlus4(o_PCPlus4),
    .i_InstrReady(i_InstrReady), .i_Redirect(i_Redirect), .i_RedirectPC(i_RedirectPC)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .o_Misaligned(o_Misaligned)
`endif
  );
  typedef struct { logic [31:0] a; int due; } mreq_t;
  mreq_t       memq[$];
  logic [31:0] sb[$], gnt_log[$], pop_pc[$], pop_p4[$];
  int          cyc = 0, lat = 1, n_cmp = 0, n_bad = 0, first_gnt = -1, first_vld = -1;
  bit          rdy = 1'b0, gnt_en = 1'b1, redir_req = 1'b0, redir_sync = 1'b0, redir_fired = 1'b0;
  logic [31:0] redir_tgt = '0, model_pc = '0;
  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction
  task automatic cycle(input int n);
    for (int k = 0; k < n; k++) begin
      bit g, rv, rd;
      logic [31:0] rdat, e;
      @(negedge clk);
      cyc++;
      rv = 1'b0;
      rdat = '0;
      if (i_RST_N && memq.size() > 0 && memq[0].due <= cyc) begin
        rv = 1'b1;
        rdat = mdata(memq[0].a);
        void'(memq.pop_front());
      end
      if (o_InstrValid && rdy) begin
        n_cmp++;
        if (first_vld < 0) first_vld = cyc;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL sb_unexpected_valid: got pc=%h, expected no instruction", o_PC);
        end else begin
          e = sb.pop_front();
          if ({o_PC, o_Instr, o_PCPlus4} !== {e, mdata(e), e + 32'd4}) begin
            n_bad++;
            $display("FAIL sb_instr: got pc=%h instr=%h pc4=%h, expected pc=%h instr=%h pc4=%h",
                     o_PC, o_Instr, o_PCPlus4, e, mdata(e), e + 32'd4);
          end
        end
        pop_pc.push_back(o_PC);
        pop_p4.push_back(o_PCPlus4);
      end
      rd = redir_req && (!redir_sync || (o_InstrValid && rdy && rv));
      g = i_RST_N && o_IMemReq && gnt_en;
      if (g) begin
        n_cmp++;
        if (o_IMemAddr !== model_pc) begin
          n_bad++;
          $display("FAIL req_addr: got %h, expected %h", o_IMemAddr, model_pc);
        end
        if (first_gnt < 0) first_gnt = cyc;
        gnt_log.push_back(o_IMemAddr);
        memq.push_back('{a: o_IMemAddr, due: cyc + lat});
        if (!rd) sb.push_back(model_pc);
        model_pc += 32'd4;
      end
      if (rd) begin
        sb.delete();
        model_pc = redir_tgt & 32'hFFFF_FFFC;
        redir_req = 1'b0;
        redir_fired = 1'b1;
      end
      i_IMemGnt = g;
      i_IMemRValid = rv;
      i_IMemRData = rdat;
      i_InstrReady = rdy;
      i_Redirect = rd;
      i_RedirectPC = redir_tgt;
    end
  endtask
  task automatic clear_logs;
    gnt_log.delete();
    pop_pc.delete();
    pop_p4.delete();
    first_gnt = -1;
    first_vld = -1;
  endtask
  task automatic do_reset;
    i_RST_N = 1'b0;
    memq.delete();
    sb.delete();
    model_pc = '0;
    redir_req = 1'b0;
    redir_sync = 1'b0;
    clear_logs();
    cycle(2);
    n_cmp++;
    if ({o_IMemReq, o_InstrValid} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_req_valid: got %b, expected 00", {o_IMemReq, o_InstrValid});
    end
    n_cmp++;
    if ({o_Instr, o_PC, o_PCPlus4} !== {32'h13, 32'h0, 32'h4}) begin
      n_bad++;
      $display("FAIL reset_outputs: got instr=%h pc=%h pc4=%h, expected 13/0/4", o_Instr, o_PC, o_PCPlus4);
    end
    i_RST_N = 1'b1;
  endtask
  task automatic test_reset;
    rdy = 1'b1;
    lat = 1;
    do_reset();
  endtask
  task automatic test_latency;
    lat = 1;
    rdy = 1'b1;
    do_reset();
    cycle(12);
    n_cmp++;
    if (gnt_log.size() < 3 || gnt_log[0] !== 32'h0 || gnt_log[1] !== 32'h4 || gnt_log[2] !== 32'h8) begin
      n_bad++;
      $display("FAIL lat_req_seq: got %0d grants, expected 0,4,8 first", gnt_log.size());
    end
    n_cmp++;
    if (first_vld - first_gnt !== 2) begin
      n_bad++;
      $display("FAIL lat_first_valid: got %0d cycles after grant, expected 2", first_vld - first_gnt);
    end
    n_cmp++;
    if (pop_pc.size() < 2 || pop_pc[0] !== 32'h0 || pop_pc[1] !== 32'h4 || pop_p4[0] !== 32'h4 || pop_p4[1] !== 32'h8) begin
      n_bad++;
      $display("FAIL lat_pc_seq: got %0d pops, expected pc 0,4 pc4 4,8", pop_pc.size());
    end
  endtask
  task automatic test_backpressure;
    lat = 1;
    rdy = 1'b0;
    do_reset();
    cycle(8);
    n_cmp++;
    if (gnt_log.size() !== 2 || o_IMemReq !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_credit: got %0d grants req=%b, expected 2 grants req=0", gnt_log.size(), o_IMemReq);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1);
      n_cmp++;
      if ({o_InstrValid, o_PC, o_Instr} !== {1'b1, 32'h0, mdata(32'h0)}) begin
        n_bad++;
        $display("FAIL bp_hold: got v=%b pc=%h instr=%h, expected 1/0/%h", o_InstrValid, o_PC, o_Instr, mdata(32'h0));
      end
    end
    rdy = 1'b1;
    cycle(10);
    n_cmp++;
    if (pop_pc.size() < 2 || pop_pc[0] !== 32'h0 || pop_pc[1] !== 32'h4) begin
      n_bad++;
      $display("FAIL bp_resume: got %0d pops, expected 0 then 4", pop_pc.size());
    end
  endtask
  task automatic test_redirect_outstanding;
    int n0;
    lat = 3;
    rdy = 1'b1;
    do_reset();
    for (int i = 0; i < 20 && gnt_log.size() < 2; i++) cycle(1);
    redir_tgt = 32'h100;
    redir_req = 1'b1;
    cycle(1);
    n0 = gnt_log.size();
    for (int i = 0; i < 20 && gnt_log.size() == n0; i++) begin
      cycle(1);
      n_cmp++;
      if (o_InstrValid !== 1'b0) begin
        n_bad++;
        $display("FAIL redir_stale_valid: got valid=1 pc=%h, expected 0", o_PC);
      end
    end
    n_cmp++;
    if (gnt_log.size() <= n0 || gnt_log[n0] !== 32'h100 || memq.size() !== 1) begin
      n_bad++;
      $display("FAIL redir_restart: got %0d new grants, %0d in flight, expected addr 100 with no stale", gnt_log.size() - n0, memq.size());
    end
    cycle(10);
  endtask
  task automatic test_simultaneous;
    lat = 1;
    rdy = 1'b1;
    do_reset();
    redir_tgt = 32'h40;
    redir_sync = 1'b1;
    redir_fired = 1'b0;
    redir_req = 1'b1;
    for (int i = 0; i < 30 && !redir_fired; i++) cycle(1);
    redir_sync = 1'b0;
    n_cmp++;
    if (!redir_fired) begin
      n_bad++;
      $display("FAIL simul_trigger: got no response+pop cycle, expected one within 30");
      redir_req = 1'b0;
    end
    clear_logs();
    cycle(1);
    n_cmp++;
    if (o_InstrValid !== 1'b0) begin
      n_bad++;
      $display("FAIL simul_empty: got valid=1, expected 0");
    end
    cycle(10);
    n_cmp++;
    if (pop_pc.size() == 0 || pop_pc[0] !== 32'h40) begin
      n_bad++;
      $display("FAIL simul_first_pc: got %0d pops, expected first pc 40", pop_pc.size());
    end
  endtask
  task automatic test_wrap;
    lat = 1;
    rdy = 1'b1;
    do_reset();
    cycle(3);
    redir_tgt = 32'hFFFF_FFFC;
    redir_req = 1'b1;
    cycle(1);
    clear_logs();
    cycle(12);
    n_cmp++;
    if (gnt_log.size() < 2 || gnt_log[0] !== 32'hFFFF_FFFC || gnt_log[1] !== 32'h0) begin
      n_bad++;
      $display("FAIL wrap_req: got %0d grants, expected fffffffc then 0", gnt_log.size());
    end
    n_cmp++;
    if (pop_pc.size() == 0 || pop_pc[0] !== 32'hFFFF_FFFC || pop_p4[0] !== 32'h0) begin
      n_bad++;
      $display("FAIL wrap_pc4: got %0d pops, expected pc fffffffc pc4 0", pop_pc.size());
    end
  endtask
`ifdef FETCH_MISALIGN_TRAP_EN
  task automatic test_misaligned;
    lat = 2;
    rdy = 1'b1;
    do_reset();
    cycle(4);
    redir_tgt = 32'h102;
    redir_req = 1'b1;
    cycle(1);
    for (int i = 0; i < 6; i++) begin
      cycle(1);
      n_cmp++;
      if ({o_Misaligned, o_IMemReq, o_InstrValid, o_PC} !== {3'b100, 32'h102}) begin
        n_bad++;
        $display("FAIL misal_halt: got mis=%b req=%b v=%b pc=%h, expected 1/0/0/102", o_Misaligned, o_IMemReq, o_InstrValid, o_PC);
      end
    end
    redir_tgt = 32'h200;
    redir_req = 1'b1;
    cycle(1);
    clear_logs();
    cycle(10);
    n_cmp++;
    if (o_Misaligned !== 1'b0 || gnt_log.size() == 0 || gnt_log[0] !== 32'h200) begin
      n_bad++;
      $display("FAIL misal_resume: got mis=%b grants=%0d, expected 0 with first addr 200", o_Misaligned, gnt_log.size());
    end
  endtask
`else
  task automatic test_align;
    lat = 1;
    rdy = 1'b1;
    do_reset();
    cycle(4);
    redir_tgt = 32'h106;
    redir_req = 1'b1;
    cycle(1);
    clear_logs();
    cycle(10);
    n_cmp++;
    if (gnt_log.size() == 0 || gnt_log[0] !== 32'h104 || pop_pc.size() == 0 || pop_pc[0] !== 32'h104) begin
      n_bad++;
      $display("FAIL align_mask: got %0d grants %0d pops, expected first addr/pc 104", gnt_log.size(), pop_pc.size());
    end
  endtask
`endif
  task automatic test_reset_mid;
    lat = 2;
    rdy = 1'b1;
    do_reset();
    cycle(7);
    #2 i_RST_N = 1'b0;
    #1;
    n_cmp++;
    if ({o_IMemReq, o_InstrValid, o_Instr, o_PC, o_PCPlus4} !== {2'b00, 32'h13, 32'h0, 32'h4}) begin
      n_bad++;
      $display("FAIL reset_mid: got req=%b v=%b instr=%h pc=%h pc4=%h, expected 0/0/13/0/4",
               o_IMemReq, o_InstrValid, o_Instr, o_PC, o_PCPlus4);
    end
    do_reset();
    cycle(10);
    n_cmp++;
    if (gnt_log.size() == 0 || gnt_log[0] !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_mid_restart: got %0d grants, expected first addr 0", gnt_log.size());
    end
  endtask
  task automatic test_back_to_back;
    lat = 2;
    rdy = 1'b1;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      rdy = 1'($urandom_range(0, 1));
      gnt_en = 1'($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 24) == 0) begin
        redir_tgt = $urandom() & 32'hFFFF_FFFC;
        redir_req = 1'b1;
      end
      cycle(1);
    end
    rdy = 1'b1;
    gnt_en = 1'b1;
    cycle(10);
    n_cmp++;
    if (pop_pc.size() < 20) begin
      n_bad++;
      $display("FAIL b2b_progress: got %0d pops, expected at least 20", pop_pc.size());
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_latency();
    test_backpressure();
    test_redirect_outstanding();
    test_simultaneous();
    test_wrap();
`ifdef FETCH_MISALIGN_TRAP_EN
    test_misaligned();
`else
    test_align();
`endif
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
